// File: rtl/wash_pkg.sv
// Shared types and constants for the wash-line controllers and the water-inlet arbiter.
package wash_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GUARD = 2'd2
    } arb_state_t;

    localparam int HOLD_CNT_W   = 8;
    localparam int GUARD_CNT_W  = 4;
    localparam int MAX_HOLD_DEF = 7;
    localparam int GUARD_DEF    = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         eligible,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0]    off_idx [N_REQ];
    logic [N_REQ-1:0] hit;

    // off_idx[k] is the machine index k places after the pointer; rr_ptr < N_REQ keeps sum < 2*N_REQ.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_off
        logic [IW:0] sum;
        assign sum          = {1'b0, rr_ptr} + (IW+1)'(gi);
        assign off_idx[gi]  = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ)) : sum[IW-1:0];
        assign hit[gi]      = eligible[off_idx[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = off_idx[k];
            end
        end
    end

endmodule

// File: rtl/wash_water_arbiter.sv
// Round-robin water-valve arbiter with maximum hold time, revoke lockout and settle guard gap.
module wash_water_arbiter
    import wash_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int GUARD    = GUARD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic                     pause_all,
    output logic [N_REQ-1:0]         grant,
    output logic                     grant_vld,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     expire,
    output logic [$clog2(N_REQ)-1:0] expire_id
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t             state_reg,     state_next;
    logic [N_REQ-1:0]       grant_reg,     grant_next;
    logic [IW-1:0]          grant_id_reg,  grant_id_next;
    logic                   expire_reg,    expire_next;
    logic [IW-1:0]          expire_id_reg, expire_id_next;
    logic [IW-1:0]          rr_ptr_reg,    rr_ptr_next;
    logic [N_REQ-1:0]       lockout_reg,   lockout_next;
    logic [HOLD_CNT_W-1:0]  hold_cnt_reg,  hold_cnt_next;
    logic [GUARD_CNT_W-1:0] guard_cnt_reg, guard_cnt_next;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] lock_set;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    after_owner;
    logic             close_grant;

    assign eligible = req & ~lockout_reg;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_reg),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    assign after_owner = (grant_id_reg == IW'(N_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    // A machine stays locked out only while it keeps req high after being revoked.
    assign lockout_next = (lockout_reg & req) | lock_set;

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        grant_id_next  = grant_id_reg;
        expire_next    = 1'b0;
        expire_id_next = expire_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        hold_cnt_next  = hold_cnt_reg;
        guard_cnt_next = guard_cnt_reg;
        lock_set       = '0;
        close_grant    = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_next    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    grant_id_next = pick_idx;
                    hold_cnt_next = '0;
                    state_next    = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                // Release is checked first so a same-cycle drop never counts as a revoke.
                if (!req[grant_id_reg]) begin
                    close_grant = 1'b1;
                end else if (!pause_all && hold_cnt_reg == HOLD_CNT_W'(MAX_HOLD - 1)) begin
                    close_grant            = 1'b1;
                    expire_next            = 1'b1;
                    expire_id_next         = grant_id_reg;
                    lock_set[grant_id_reg] = 1'b1;
                end else if (!pause_all) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end

                if (close_grant) begin
                    grant_next     = '0;
                    grant_id_next  = '0;
                    rr_ptr_next    = after_owner;
                    hold_cnt_next  = '0;
                    guard_cnt_next = '0;
                    state_next     = ARB_GUARD;
                end
            end

            ARB_GUARD: begin
                if (!pause_all) begin
                    if (guard_cnt_reg == GUARD_CNT_W'(GUARD - 1)) begin
                        guard_cnt_next = '0;
                        if (pick_found) begin
                            grant_next    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            grant_id_next = pick_idx;
                            hold_cnt_next = '0;
                            state_next    = ARB_GRANT;
                        end else begin
                            state_next = ARB_IDLE;
                        end
                    end else begin
                        guard_cnt_next = guard_cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                grant_next    = '0;
                grant_id_next = '0;
                state_next    = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            grant_reg     <= '0;
            grant_id_reg  <= '0;
            expire_reg    <= 1'b0;
            expire_id_reg <= '0;
            rr_ptr_reg    <= '0;
            lockout_reg   <= '0;
            hold_cnt_reg  <= '0;
            guard_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            grant_id_reg  <= grant_id_next;
            expire_reg    <= expire_next;
            expire_id_reg <= expire_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            lockout_reg   <= lockout_next;
            hold_cnt_reg  <= hold_cnt_next;
            guard_cnt_reg <= guard_cnt_next;
        end
    end

    assign grant     = grant_reg;
    assign grant_vld = |grant_reg;
    assign grant_id  = grant_id_reg;
    assign expire    = expire_reg;
    assign expire_id = expire_id_reg;

endmodule

// File: tb/tb_wash_water_arbiter.sv
// Directed bench for wash_water_arbiter with a cycle-level behavioural model compared every cycle.
module tb_wash_water_arbiter;

    localparam int N  = 4;
    localparam int MH = 7;
    localparam int G  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         pause_all = 1'b0;
    logic [N-1:0] grant;
    logic         grant_vld;
    logic [1:0]   grant_id;
    logic         expire;
    logic [1:0]   expire_id;

    int n_vec = 0;
    int n_err = 0;

    wash_water_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .GUARD(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pause_all (pause_all),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .expire    (expire),
        .expire_id (expire_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    // Model: owner (-1 = valve closed), hold cycles left, guard cycles left, per-machine lock.
    int m_owner, m_hold_left, m_guard_left, m_ptr, m_expire_id;
    bit m_expire;
    bit m_lock [N];

    function automatic int m_pick();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && !m_lock[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit nl [N];
        int p;
        if (rst) begin
            m_owner = -1; m_hold_left = 0; m_guard_left = 0; m_ptr = 0;
            m_expire = 0; m_expire_id = 0;
            for (int j = 0; j < N; j++) m_lock[j] = 0;
        end else begin
            for (int j = 0; j < N; j++) nl[j] = m_lock[j] && req[j];
            m_expire = 0;
            if (m_owner >= 0) begin
                if (!req[m_owner]) begin
                    m_ptr = (m_owner + 1) % N; m_owner = -1; m_guard_left = G;
                end else if (!pause_all) begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_expire = 1; m_expire_id = m_owner; nl[m_owner] = 1;
                        m_ptr = (m_owner + 1) % N; m_owner = -1; m_guard_left = G;
                    end
                end
            end else if (m_guard_left > 0) begin
                if (!pause_all) begin
                    m_guard_left--;
                    if (m_guard_left == 0) begin
                        p = m_pick();
                        if (p >= 0) begin m_owner = p; m_hold_left = MH; end
                    end
                end
            end else begin
                p = m_pick();
                if (p >= 0) begin m_owner = p; m_hold_left = MH; end
            end
            m_lock = nl;
        end
    end

    always @(negedge clk) begin
        int mg;
        if (!rst) begin
            mg = (m_owner >= 0) ? (1 << m_owner) : 0;
            chk("model_grant", grant, mg);
            chk("model_grant_vld", grant_vld, mg != 0);
            chk("model_grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
            chk("model_expire", expire, m_expire);
            if (m_expire) chk("model_expire_id", expire_id, m_expire_id);
        end
    end

    initial begin
        int hc;
        bit seen;
        tick(3);
        rst = 1'b0;
        chk("rst_grant", grant, 0);
        chk("rst_grant_vld", grant_vld, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_expire", expire, 0);

        // Single request, release after 5 cycles, guard gap.
        req = 4'b0100;
        tick(1);
        chk("t1_grant", grant, 4'b0100);
        chk("t1_grant_id", grant_id, 2);
        tick(4);
        req = 4'b0000;
        tick(1);
        chk("t1_release", grant, 0);
        tick(1);
        chk("t1_guard", grant, 0);
        tick(3);

        // All requesting; rotation 0,1,2,3,0 with a 2-cycle gap.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int gap, id;
            gap = 0;
            while (!grant_vld && gap < 20) begin
                gap++;
                tick(1);
            end
            chk("t2_order", grant_id, k % 4);
            if (k > 0) chk("t2_gap", gap, 2);
            id = grant_id;
            tick(2);
            req[id] = 1'b0;
            tick(1);
            req[id] = 1'b1;
        end
        req = 4'b0000;
        tick(4);

        // Held request is revoked after 7 cycles and locked out until it drops.
        do_reset();
        req = 4'b0010;
        tick(1);
        hc = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (expire) seen = 1;
            else begin
                if (grant_vld) hc++;
                tick(1);
            end
        end
        chk("t3_expire_seen", seen, 1);
        chk("t3_expire_id", expire_id, 1);
        chk("t3_hold_cycles", hc, 7);
        tick(10);
        chk("t3_locked", grant_vld, 0);
        req = 4'b0000;
        tick(1);
        req = 4'b0010;
        tick(1);
        chk("t3_regrant", grant, 4'b0010);
        req = 4'b0000;
        tick(4);

        // Pause mid-hold delays the revoke by the paused cycles.
        do_reset();
        req = 4'b1000;
        tick(1);
        chk("t4_grant", grant, 4'b1000);
        tick(2);
        pause_all = 1'b1;
        tick(10);
        chk("t4_paused_grant", grant, 4'b1000);
        chk("t4_paused_expire", expire, 0);
        pause_all = 1'b0;
        tick(4);
        chk("t4_still_held", grant, 4'b1000);
        tick(1);
        chk("t4_expire", expire, 1);
        chk("t4_expire_id", expire_id, 3);
        req = 4'b0000;
        tick(4);

        // Release on the revoke cycle: no expire, no lockout.
        do_reset();
        req = 4'b0001;
        tick(1);
        chk("t5_grant", grant, 4'b0001);
        tick(6);
        req = 4'b0000;
        tick(1);
        chk("t5_no_expire", expire, 0);
        chk("t5_released", grant, 0);
        req = 4'b0001;
        tick(2);
        chk("t5_no_lockout", grant, 4'b0001);
        req = 4'b0000;
        tick(4);

        // Asynchronous reset mid-grant; pointer returns to 0.
        do_reset();
        req = 4'b0010;
        tick(1);
        chk("t6_grant1", grant, 4'b0010);
        req = 4'b0100;
        tick(3);
        chk("t6_grant2", grant, 4'b0100);
        req = 4'b0110;
        tick(1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant", grant, 0);
        chk("t6_async_vld", grant_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        chk("t6_post_grant", grant, 4'b0010);
        chk("t6_post_id", grant_id, 1);
        req = 4'b0000;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
